// File: rtl/regfile_2r1w.sv
// Parametrised 2-read/1-write register file with write-first bypass, registered reads
// and a self-clearing sequence after reset. Optional macro: REGFILE_ZERO_REG_EN (entry 0 reads as zero).
module regfile_2r1w #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              re_a,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic              re_b,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] data_a,
  output logic [DATA_W-1:0] data_b,
  output logic              valid_a,
  output logic              valid_b,
  output logic              ready
);

  localparam int DEPTH = 1 << ADDR_W;

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] clr_cnt_q;
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic              ready_q;
  logic              valid_a_q;
  logic              valid_b_q;
  logic [DATA_W-1:0] data_a_q;
  logic [DATA_W-1:0] data_b_q;

  logic              arr_we;
  logic [ADDR_W-1:0] arr_addr;
  logic [DATA_W-1:0] arr_wdata;
  logic [DATA_W-1:0] rd_a_d;
  logic [DATA_W-1:0] rd_b_d;

  // Write-first: a same-cycle write to the read address is forwarded to the read port.
  always_comb begin
    rd_a_d = (we && (wr_addr == rd_addr_a)) ? wr_data : regs_q[rd_addr_a];
    rd_b_d = (we && (wr_addr == rd_addr_b)) ? wr_data : regs_q[rd_addr_b];
    if (ZERO_REG && (rd_addr_a == '0)) rd_a_d = '0;
    if (ZERO_REG && (rd_addr_b == '0)) rd_b_d = '0;
  end

  // The array has one write port shared by the clear sequence and the writeback port.
  always_comb begin
    arr_we    = 1'b0;
    arr_addr  = wr_addr;
    arr_wdata = wr_data;
    if (!rst) begin
      if (state_q == CLEAR) begin
        arr_we    = 1'b1;
        arr_addr  = clr_cnt_q;
        arr_wdata = '0;
      end else if (we && !(ZERO_REG && (wr_addr == '0))) begin
        arr_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (arr_we) regs_q[arr_addr] <= arr_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      ready_q   <= 1'b0;
      valid_a_q <= 1'b0;
      valid_b_q <= 1'b0;
      data_a_q  <= '0;
      data_b_q  <= '0;
    end else begin
      case (state_q)
        CLEAR: begin
          clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
          valid_a_q <= 1'b0;
          valid_b_q <= 1'b0;
          if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
            state_q <= READY;
            ready_q <= 1'b1;
          end
        end
        READY: begin
          valid_a_q <= re_a;
          valid_b_q <= re_b;
          if (re_a) data_a_q <= rd_a_d;
          if (re_b) data_b_q <= rd_b_d;
        end
        default: begin
          state_q <= CLEAR;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign data_a  = data_a_q;
  assign data_b  = data_b_q;
  assign valid_a = valid_a_q;
  assign valid_b = valid_b_q;
  assign ready   = ready_q;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed bench for regfile_2r1w: read expectations go into per-port queues and a
// negedge monitor pops them whenever a valid flag is presented.
module tb_regfile_2r1w;

  logic        clk;
  logic        rst;
  logic        we;
  logic [1:0]  wr_addr;
  logic [31:0] wr_data;
  logic        re_a;
  logic [1:0]  rd_addr_a;
  logic        re_b;
  logic [1:0]  rd_addr_b;
  logic [31:0] data_a;
  logic [31:0] data_b;
  logic        valid_a;
  logic        valid_b;
  logic        ready;

  logic [31:0] exp_a_q[$];
  logic [31:0] exp_b_q[$];
  int          checks;
  int          errors;

`ifdef REGFILE_ZERO_REG_EN
  localparam logic [31:0] ZR_EXP = 32'h0;
`else
  localparam logic [31:0] ZR_EXP = 32'h55;
`endif

  regfile_2r1w #(.DATA_W(32), .ADDR_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .we        (we),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .re_a      (re_a),
    .rd_addr_a (rd_addr_a),
    .re_b      (re_b),
    .rd_addr_b (rd_addr_b),
    .data_a    (data_a),
    .data_b    (data_b),
    .valid_a   (valid_a),
    .valid_b   (valid_b),
    .ready     (ready)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Handshake: valid_x high for one cycle means data_x carries the result of the read
  // issued on the previous rising edge; with valid_x low, data_x holds its last value.
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Driver tasks
  task automatic drive(input logic w, input logic [1:0] wa, input logic [31:0] wd,
                       input logic ra, input logic [1:0] aa,
                       input logic rb, input logic [1:0] ab);
    we = w; wr_addr = wa; wr_data = wd;
    re_a = ra; rd_addr_a = aa; re_b = rb; rd_addr_b = ab;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 2'd0, 32'h0, 1'b0, 2'd0, 1'b0, 2'd0);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (valid_a === 1'b1) begin
      checks++;
      if (exp_a_q.size() == 0) begin
        errors++;
        $display("FAIL port_a_unexpected: got valid data %h, expected no valid", data_a);
      end else begin
        logic [31:0] e;
        e = exp_a_q.pop_front();
        if (data_a !== e) begin
          errors++;
          $display("FAIL port_a_data: got %h, expected %h", data_a, e);
        end
      end
    end
    if (valid_b === 1'b1) begin
      checks++;
      if (exp_b_q.size() == 0) begin
        errors++;
        $display("FAIL port_b_unexpected: got valid data %h, expected no valid", data_b);
      end else begin
        logic [31:0] e;
        e = exp_b_q.pop_front();
        if (data_b !== e) begin
          errors++;
          $display("FAIL port_b_data: got %h, expected %h", data_b, e);
        end
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    idle();

    // Reset held for two edges with traffic that must be ignored.
    drive(1'b1, 2'd1, 32'h1111_1111, 1'b1, 2'd1, 1'b1, 2'd1);
    tick();
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_valid", {30'd0, valid_a, valid_b}, 32'd0);
    check("rst_data_a", data_a, 32'h0);
    check("rst_data_b", data_b, 32'h0);
    tick();
    rst = 1'b0;

    // Clear sequence: ready after exactly 4 edges; reads/writes meanwhile ignored.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'd2, 32'h7777_7777, 1'b1, 2'(i), 1'b1, 2'(i));
      tick();
      check($sformatf("clear_ready_%0d", i), {31'd0, ready}, (i == 3) ? 32'd1 : 32'd0);
    end
    check("clear_data_a", data_a, 32'h0);

    // All entries read zero on both ports.
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 2'd0, 32'h0, 1'b1, 2'(i), 1'b1, 2'(3 - i));
      exp_a_q.push_back(32'h0);
      exp_b_q.push_back(32'h0);
      tick();
    end

    // Basic write then dual read.
    drive(1'b1, 2'd2, 32'hDEAD_BEEF, 1'b0, 2'd0, 1'b0, 2'd0); tick();
    drive(1'b1, 2'd3, 32'h1234_5678, 1'b0, 2'd0, 1'b0, 2'd0); tick();
    drive(1'b0, 2'd0, 32'h0, 1'b1, 2'd2, 1'b1, 2'd3);
    exp_a_q.push_back(32'hDEAD_BEEF);
    exp_b_q.push_back(32'h1234_5678);
    tick();

    // Bypass on both ports, then a later plain read.
    drive(1'b1, 2'd1, 32'hA5A5_A5A5, 1'b1, 2'd1, 1'b1, 2'd1);
    exp_a_q.push_back(32'hA5A5_A5A5);
    exp_b_q.push_back(32'hA5A5_A5A5);
    tick();
    drive(1'b0, 2'd0, 32'h0, 1'b1, 2'd1, 1'b1, 2'd2);
    exp_a_q.push_back(32'hA5A5_A5A5);
    exp_b_q.push_back(32'hDEAD_BEEF);
    tick();

    // Hold: data_a keeps the last read while addr 2 is overwritten.
    drive(1'b0, 2'd0, 32'h0, 1'b1, 2'd2, 1'b0, 2'd0);
    exp_a_q.push_back(32'hDEAD_BEEF);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'd2, 32'h0, 1'b0, 2'd0, 1'b0, 2'd0);
      tick();
      check($sformatf("hold_data_a_%0d", i), data_a, 32'hDEAD_BEEF);
      check($sformatf("hold_valid_a_%0d", i), {31'd0, valid_a}, 32'd0);
    end
    drive(1'b0, 2'd0, 32'h0, 1'b1, 2'd2, 1'b0, 2'd0);
    exp_a_q.push_back(32'h0);
    tick();

    // Reset mid-operation with a write in the reset cycle.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'(i), 32'hFFFF_FFFF, 1'b0, 2'd0, 1'b0, 2'd0);
      tick();
    end
    rst = 1'b1;
    drive(1'b1, 2'd0, 32'h0000_0012, 1'b1, 2'd0, 1'b0, 2'd0);
    tick();
    rst = 1'b0;
    check("midrst_ready", {31'd0, ready}, 32'd0);
    idle();
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("midrst_clear_ready_%0d", i), {31'd0, ready}, (i == 3) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 2'd0, 32'h0, 1'b1, 2'(i), 1'b1, 2'(i));
      exp_a_q.push_back(32'h0);
      exp_b_q.push_back(32'h0);
      tick();
    end

    // Entry 0: write with same-cycle read, then a later read.
    drive(1'b1, 2'd0, 32'h55, 1'b1, 2'd0, 1'b1, 2'd0);
    exp_a_q.push_back(ZR_EXP);
    exp_b_q.push_back(ZR_EXP);
    tick();
    drive(1'b0, 2'd0, 32'h0, 1'b1, 2'd0, 1'b0, 2'd0);
    exp_a_q.push_back(ZR_EXP);
    tick();

    idle();
    tick();
    tick();
    check("drain_a", 32'(exp_a_q.size()), 32'd0);
    check("drain_b", 32'(exp_b_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
